// File: rtl/ds_dac_pkg.sv
// ---------------------------------------------------------------------------
// ds_dac_pkg -- shared constants and helpers for the multi-channel
// delta-sigma DAC (ds_dac_mc / ds_mod_core).
//
// Contents:
//   ACC_EXT  : extra accumulator bits on top of the sample width
//   SAT_W    : width of the exact intermediate arithmetic
//   INIT     : accumulator value after reset or a mode change
//   mode_e   : modulator order
//   fs_of()  : full-scale value 2^width - 1
//   sat_add(): signed add clipped to a signed acc_w-bit range
// ---------------------------------------------------------------------------
package ds_dac_pkg;

  localparam int ACC_EXT = 4;

  // Intermediate sums are formed exactly at this width and only then clipped,
  // so no partial result can wrap before saturation is applied.
  localparam int SAT_W = 64;

  localparam logic signed [SAT_W-1:0] INIT = -64'sd1;

  typedef enum logic {
    MODE_FIRST  = 1'b0,
    MODE_SECOND = 1'b1
  } mode_e;

  function automatic logic [SAT_W-1:0] fs_of(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      acc_w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sum   = a + b;
    max_v = $signed((64'd1 << (acc_w - 1)) - 64'd1);
    min_v = ~max_v;  // two's complement: -max - 1
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/ds_mod_core.sv
// ---------------------------------------------------------------------------
// ds_mod_core -- one delta-sigma modulator channel (first or second order).
//
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   tick    : update strobe; accumulators and bit_out change only here
//   reinit  : force both accumulators to INIT (mode change), wins over tick
//   order2  : 0 = first-order, 1 = second-order
//   din     : unsigned sample (active register of this channel)
//   bit_out : registered 1-bit density output
// ---------------------------------------------------------------------------
module ds_mod_core
  import ds_dac_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             reinit,
  input  logic             order2,
  input  logic [WIDTH-1:0] din,
  output logic             bit_out
);

  localparam int AW = WIDTH + ACC_EXT;

  logic signed [AW-1:0]    a1_q, a1_d;
  logic signed [AW-1:0]    a2_q, a2_d;
  logic                    bit_q, bit_d;

  logic signed [SAT_W-1:0] fb_w;
  logic signed [SAT_W-1:0] delta_w;
  logic signed [SAT_W-1:0] a1_new_w;
  logic signed [SAT_W-1:0] a2_new_w;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so
    // no path can leave a signal unassigned and infer a latch.
    a1_d  = a1_q;
    a2_d  = a2_q;
    bit_d = bit_q;

    // Feedback is the full-scale value whenever the output currently reads 1.
    fb_w     = bit_q ? $signed(fs_of(WIDTH)) : '0;
    delta_w  = $signed({{(SAT_W-WIDTH){1'b0}}, din}) - fb_w;
    a1_new_w = sat_add(SAT_W'(a1_q), delta_w, AW);
    // The second integrator consumes the freshly updated first stage.
    a2_new_w = sat_add(SAT_W'(a2_q), a1_new_w - fb_w, AW);

    if (reinit) begin
      a1_d = AW'(INIT);
      a2_d = AW'(INIT);
    end else if (tick) begin
      a1_d = AW'(a1_new_w);
      if (order2) begin
        a2_d  = AW'(a2_new_w);
        bit_d = ~a2_new_w[SAT_W-1];
      end else begin
        bit_d = ~a1_new_w[SAT_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      a1_q  <= AW'(INIT);
      a2_q  <= AW'(INIT);
      bit_q <= 1'b0;
    end else begin
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/ds_dac_mc.sv
// ---------------------------------------------------------------------------
// ds_dac_mc -- multi-channel delta-sigma DAC with double-buffered samples.
//
// Samples are written into per-channel staging registers through a
// valid/ready port and copied to the active registers all at once on commit,
// so every channel switches to its new value on the same modulator update.
//
// Parameters:
//   WIDTH    : sample width (unsigned)
//   CHANNELS : number of modulator channels (1..16)
//   DIV      : modulator update period in clk cycles (1..256)
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   s_valid    : sample write request
//   s_ready    : sample write accept (1 outside reset)
//   s_chan     : target channel; values >= CHANNELS are dropped
//   s_data     : sample value
//   commit     : copy staging -> active, latch order2 as the new mode
//   order2     : 0 = first-order, 1 = second-order (used on commit only)
//   bit_out    : one registered density bit per channel
// ---------------------------------------------------------------------------
module ds_dac_mc
  import ds_dac_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 2,
  parameter  int DIV      = 1,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CW-1:0]       s_chan,
  input  logic [WIDTH-1:0]    s_data,
  input  logic                commit,
  input  logic                order2,
  output logic [CHANNELS-1:0] bit_out
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic             ready_q;
  logic [WIDTH-1:0] stg_q [CHANNELS];
  logic [WIDTH-1:0] stg_d [CHANNELS];
  logic [WIDTH-1:0] act_q [CHANNELS];
  logic [WIDTH-1:0] act_d [CHANNELS];
  mode_e            mode_q, mode_d;
  logic [DW-1:0]    div_q, div_d;

  logic             chan_ok;
  logic             wr_en;
  logic             tick;
  logic             reinit;

  assign s_ready = ready_q;
  assign chan_ok = (32'(s_chan) < CHANNELS);
  assign wr_en   = s_valid & ready_q & chan_ok;
  assign tick    = (div_q == DW'(DIV - 1));
  // Only an actual change of order restarts the integrators; re-committing
  // the same order leaves the running modulators undisturbed.
  assign reinit  = commit & (mode_e'(order2) != mode_q);

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    mode_d = commit ? mode_e'(order2) : mode_q;
    for (int i = 0; i < CHANNELS; i++) begin
      stg_d[i] = stg_q[i];
      if (wr_en && (s_chan == CW'(i))) begin
        stg_d[i] = s_data;
      end
      // Taking the post-write staging value lets a same-cycle write reach
      // the active register together with the commit.
      act_d[i] = commit ? stg_d[i] : act_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      mode_q  <= MODE_FIRST;
      div_q   <= '0;
      // NOTE: the sample arrays are small flop banks, not RAM, and must
      // restart at zero so no stale sample survives a reset.
      for (int i = 0; i < CHANNELS; i++) begin
        stg_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      mode_q  <= mode_d;
      div_q   <= div_d;
      for (int i = 0; i < CHANNELS; i++) begin
        stg_q[i] <= stg_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ds_mod_core #(
      .WIDTH(WIDTH)
    ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .reinit (reinit),
      .order2 (mode_q == MODE_SECOND),
      .din    (act_q[g]),
      .bit_out(bit_out[g])
    );
  end

endmodule

// File: tb/tb_ds_dac_mc.sv
// ---------------------------------------------------------------------------
// tb_ds_dac_mc -- self-checking bench for ds_dac_mc.
//
// Two instances (DIV = 1 and DIV = 4, three channels each) share the same
// stimulus. A behavioural model tracks staging, active, mode and the
// per-channel integrators with plain integer arithmetic and is compared
// against both instances on every falling edge. Directed scenarios add
// literal expectations for ones density, latency, out-of-range writes,
// divider spacing and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_ds_dac_mc;

  localparam int     W    = 16;
  localparam int     CH   = 3;
  localparam longint FS   = 65535;
  localparam longint AMAX = (longint'(1) << (W + 3)) - 1;
  localparam longint AMIN = -AMAX - 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic [1:0]    s_chan  = '0;
  logic [W-1:0]  s_data  = '0;
  logic          commit  = 1'b0;
  logic          order2  = 1'b0;
  logic          s_ready1, s_ready4;
  logic [CH-1:0] bo1, bo4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ds_dac_mc #(.WIDTH(W), .CHANNELS(CH), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
    .s_chan(s_chan), .s_data(s_data), .commit(commit), .order2(order2),
    .bit_out(bo1)
  );

  ds_dac_mc #(.WIDTH(W), .CHANNELS(CH), .DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
    .s_chan(s_chan), .s_data(s_data), .commit(commit), .order2(order2),
    .bit_out(bo4)
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     div_of [2] = '{1, 4};
  longint m_stg [CH];
  longint m_act [CH];
  bit     m_mode;
  bit     m_rdy;
  longint m_a1 [2][CH];
  longint m_a2 [2][CH];
  bit     m_bit [2][CH];
  int     m_cnt [2];
  bit     model_live = 1'b0;

  function automatic longint clip(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit     we, rein, tk;
    longint fb, n1, n2;
    if (!rst_n) begin
      m_mode = 1'b0;
      m_rdy  = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_stg[c] = 0;
        m_act[c] = 0;
      end
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        for (int c = 0; c < CH; c++) begin
          m_a1[k][c] = -1; m_a2[k][c] = -1; m_bit[k][c] = 1'b0;
        end
      end
    end else begin
      we   = s_valid && m_rdy && (int'(s_chan) < CH);
      rein = commit && (order2 != m_mode);
      for (int k = 0; k < 2; k++) begin
        tk = (m_cnt[k] == div_of[k] - 1);
        for (int c = 0; c < CH; c++) begin
          if (rein) begin
            m_a1[k][c] = -1; m_a2[k][c] = -1;
          end else if (tk) begin
            fb = m_bit[k][c] ? FS : 0;
            n1 = clip(m_a1[k][c] + m_act[c] - fb);
            m_a1[k][c] = n1;
            if (m_mode) begin
              n2 = clip(m_a2[k][c] + n1 - fb);
              m_a2[k][c]  = n2;
              m_bit[k][c] = (n2 >= 0);
            end else begin
              m_bit[k][c] = (n1 >= 0);
            end
          end
        end
        m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
      end
      if (we) m_stg[s_chan] = longint'(s_data);
      if (commit) begin
        for (int c = 0; c < CH; c++) m_act[c] = m_stg[c];
        m_mode = order2;
      end
      m_rdy = 1'b1;
    end
    model_live = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [CH:0] e1, e4;
    if (model_live) begin
      e1[CH] = m_rdy;
      e4[CH] = m_rdy;
      for (int c = 0; c < CH; c++) begin
        e1[c] = m_bit[0][c];
        e4[c] = m_bit[1][c];
      end
      check("model_div1", 64'({s_ready1, bo1}), 64'(e1));
      check("model_div4", 64'({s_ready4, bo4}), 64'(e4));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int val);
    @(negedge clk);
    s_valid = 1'b1; s_chan = 2'(ch); s_data = W'(val);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_commit(input bit o2);
    @(negedge clk);
    commit = 1'b1; order2 = o2;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int ones, last, t;
    int iv [$];
    bit seen;
    logic prev;

    // Reset state
    idle(3);
    check("reset_ready", 64'(s_ready1), 64'd0);
    check("reset_bits", 64'(bo1), 64'd0);
    rst_n = 1'b1;
    idle(2);
    check("ready_after_reset", 64'(s_ready1), 64'd1);

    // ch0 = 0 -> constant 0, ch1 = FS -> constant 1 from the 2nd tick on
    wr(0, 16'h0000);
    wr(1, 16'hFFFF);
    do_commit(1'b0);
    check("fs_before_tick", 64'(bo1[1]), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("zero_const", 64'(bo1[0]), 64'd0);
      check("fs_const", 64'(bo1[1]), 64'd1);
    end

    // Write without commit has no effect; commit makes ch0 toggle quickly
    wr(0, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_commit_hold", 64'(bo1[0]), 64'd0);
    end
    do_commit(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bo1[0]) seen = 1'b1;
    end
    check("toggle_within_2", 64'(seen), 64'd1);

    // DIV = 4: changes of the half-scale channel settle 4 cycles apart
    prev = bo4[0];
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bo4[0] !== prev) iv.push_back(i);
      prev = bo4[0];
    end
    check("div4_changes", 64'(iv.size() >= 8), 64'd1);
    if (iv.size() >= 4) begin
      for (int j = iv.size() - 3; j < iv.size(); j++)
        check("div4_spacing", 64'(iv[j] - iv[j-1]), 64'd4);
    end

    // Out-of-range channel write dropped
    wr(3, 16'h1234);
    do_commit(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("oor_ch2_zero", 64'(bo1[2]), 64'd0);
      check("oor_ch1_fs", 64'(bo1[1]), 64'd1);
    end

    // Density 0x4000 first order: restart integrators by toggling mode
    wr(0, 16'h4000);
    do_commit(1'b1);
    do_commit(1'b0);
    ones = 0;
    repeat (8192) begin
      @(negedge clk);
      ones += int'(bo1[0]);
    end
    last = ones - 2048;
    check("density_o1", 64'((last >= -1) && (last <= 1)), 64'd1);
    if (last < -1 || last > 1) $display("  first-order ones = %0d", ones);

    // Same density, second order
    do_commit(1'b1);
    ones = 0;
    repeat (8192) begin
      @(negedge clk);
      ones += int'(bo1[0]);
    end
    last = ones - 2048;
    check("density_o2", 64'((last >= -2) && (last <= 2)), 64'd1);
    if (last < -2 || last > 2) $display("  second-order ones = %0d", ones);

    // Randomised writes, commits and mode changes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 2) == 0);
      s_chan  = 2'($urandom_range(0, 3));
      t = $urandom_range(0, 3);
      case (t)
        0:       s_data = '0;
        1:       s_data = '1;
        default: s_data = W'($urandom);
      endcase
      commit = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) order2 = ~order2;
    end
    @(negedge clk);
    s_valid = 1'b0; commit = 1'b0;

    // Switch to second order while running, then a 1-cycle reset pulse
    wr(0, 16'h6000);
    do_commit(1'b0);
    idle(5);
    do_commit(1'b1);
    idle(20);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("pulse_ready", 64'(s_ready1), 64'd0);
    check("pulse_bits1", 64'(bo1), 64'd0);
    check("pulse_bits4", 64'(bo4), 64'd0);
    idle(6);
    check("post_reset_ready", 64'(s_ready1), 64'd1);
    check("post_reset_bits1", 64'(bo1), 64'd0);
    check("post_reset_bits4", 64'(bo4), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds_dac_mc.md
DS_DAC_MC -- requirements
Module: ds_dac_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input sample width, unsigned.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent modulator channels, range 1..16.
REQ-003 SHALL have parameter DIV, default 1: modulator update period in clk cycles, range 1..256.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1: sample write request.
REQ-007 SHALL have port s_ready, output, 1: sample write accept.
REQ-008 SHALL have port s_chan, input, CW = max(1, clog2(CHANNELS)): target channel.
REQ-009 SHALL have port s_data, input, WIDTH: sample value.
REQ-010 SHALL have port commit, input, 1: copy all staging registers to active registers.
REQ-011 SHALL have port order2, input, 1: 0 = first-order modulation, 1 = second-order; sampled only on commit.
REQ-012 SHALL have port bit_out, output, CHANNELS: one registered 1-bit density output per channel.

Function
REQ-013 SHALL drive s_ready to 1 in every cycle except reset cycles; write occurs when s_valid and s_ready are both 1.
REQ-014 SHALL store an accepted s_data into staging[s_chan], and SHALL drop writes with s_chan >= CHANNELS with no side effect.
REQ-015 SHALL, on commit, load active[i] <= staging[i] for all channels in one cycle; a write and a commit in the same cycle SHALL pass the new value to active for that channel.
REQ-016 SHALL latch order2 into the mode register on commit; a mode change SHALL reinitialise all accumulators to INIT in the same cycle.
REQ-017 SHALL assert a tick once every DIV cycles from a wrapping counter (0..DIV-1); tick = counter == DIV-1; with DIV = 1, tick is asserted every cycle.
REQ-018 SHALL update accumulators and bit_out only on tick; bit_out SHALL hold between ticks.
REQ-019 SHALL use feedback fb = bit_out[i] ? FS : 0, with FS = 2^WIDTH - 1.
REQ-020 In first-order mode, the block SHALL compute a1 <= a1 + active - fb, and the next value of bit_out SHALL be the complement of the sign of the new a1.
REQ-021 In second-order mode, the block SHALL compute a1 <= a1 + active - fb and a2 <= a2 + a1_new - fb, and the next value of bit_out SHALL be the complement of the sign of the new a2.
REQ-022 SHALL hold a1 and a2 as signed WIDTH+4 bits, saturating at the signed min and max with no wrap-around.
REQ-023 The long-run ones density of bit_out SHALL equal active/FS; active = 0 SHALL give constant 0, and active = FS SHALL give constant 1 after at most 2 ticks (first-order mode).
REQ-024 Latency SHALL be as follows: a commit in cycle n SHALL affect bit_out at the first tick at or after cycle n+1.

Reset
REQ-025 While rst_n = 0 at a clk edge: staging = 0, active = 0, mode = first-order, a1 = a2 = INIT (-1), divider = 0, bit_out = 0, s_ready = 0.
REQ-026 Reset asserted mid-operation SHALL discard pending staging data with no partial-commit state.

Structure
REQ-027 Package ds_dac_pkg SHALL hold the accumulator-width offset (4), INIT, the FS function of WIDTH, and the saturating-add function.
REQ-028 The per-channel modulator SHALL be the sub-module ds_mod_core (ports: clk, rst_n, tick, reinit, order2, din, bit_out), instantiated CHANNELS times; ds_dac_mc SHALL own the handshake, staging, commit and divider.

Verification
REQ-029 Scenario: reset, write ch0 = 0x0000 and ch1 = 0xFFFF, commit, DIV = 1, first-order -> bit_out[0] is 0 throughout; bit_out[1] is 1 from the 2nd tick on.
REQ-030 Scenario: ch0 = 0x4000, first-order, count over 65535 ticks -> ones count is 16384 ± 1; repeat with second-order -> 16384 ± 2.
REQ-031 Scenario: write ch0 = 0x8000 without commit -> bit_out[0] stays 0; commit -> bit_out[0] toggles within 2 ticks.
REQ-032 Scenario: write with s_chan = CHANNELS (out of range), then commit -> all active registers are unchanged.
REQ-033 Scenario: DIV = 4, ch0 = 0x8000 -> bit_out[0] changes only on cycles where divider = 3, with period 8 cycles.
REQ-034 Scenario: order2 switched 0 to 1 at commit while running, then rst_n pulsed low for 1 cycle mid-stream -> accumulators are re-initialised and all outputs are 0 after reset.
